adc_scan_scheduler: RTL and testbench

Channel scheduler for the AD7928 SPI front-end. Decides which of the 8 ADC channels is converted next, using per-channel rate dividers and an optional on-demand request port. Issues one channel command per frame to the SPI driver and tags returned samples with channel and source. Sits between the control/register logic and the ADC SPI driver; its result stream feeds downstream consumers.

---
 rtl/adc_sched_pkg.sv | 17 +
 rtl/adc_rr_arbiter.sv | 31 +++
 rtl/adc_scan_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types for the AD7928 channel scan scheduler.
package adc_sched_pkg;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned CH_W   = 3;

   typedef logic [CH_W-1:0] ch_t;

   typedef struct packed {
      ch_t  ch;
      logic src;
   } tag_t;

   localparam logic SRC_SCHED  = 1'b0;
   localparam logic SRC_DEMAND = 1'b1;

endpackage

// File: rtl/adc_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i+1 upward, wrapping,
// and returns a one-hot grant plus the granted index.
module adc_rr_arbiter
   import adc_sched_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  ch_t               ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output ch_t               idx_o,
   output logic              valid_o
);

   ch_t cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      // k == NUM_CH wraps back to ptr_i itself, so it is searched last.
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         cand = ptr_i + ch_t'(k);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Channel scheduler for the AD7928 SPI driver: rate dividers, round-robin command issue and
// result tagging. Define ADC_SCHED_ONDEMAND_EN to enable the on-demand request port.
module adc_scan_scheduler #(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RATE_WIDTH = 8,
   parameter int unsigned TAG_DEPTH  = 4
) (
   input  logic                         CLK,
   input  logic                         rstn,
   input  logic                         tick,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic [NUM_CH*RATE_WIDTH-1:0] ch_rate,
   input  logic                         req_valid,
   input  logic [2:0]                   req_ch,
   output logic                         req_ready,
   output logic                         cmd_valid,
   output logic [2:0]                   cmd_ch,
   input  logic                         cmd_ready,
   input  logic                         res_valid,
   input  logic [DATA_WIDTH-1:0]        res_data,
   input  logic [2:0]                   res_ch,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [2:0]                   out_ch,
   output logic                         out_src,
   output logic [NUM_CH-1:0]            overrun,
   output logic                         err_mismatch,
   output logic                         err_orphan,
   input  logic                         err_clr
);

   import adc_sched_pkg::*;

   localparam int unsigned PTR_W = $clog2(TAG_DEPTH);

   // Rate dividers and pending bits
   logic [NUM_CH-1:0][RATE_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]                 pending_q, pending_d;
   logic [NUM_CH-1:0]                 due;
   logic [NUM_CH-1:0]                 overrun_q, overrun_d, ovr_set;
   logic [RATE_WIDTH-1:0]             rate;

   // Arbitration and command slot
   ch_t               rr_ptr_q, rr_ptr_d;
   logic              cmd_valid_q, cmd_valid_d;
   ch_t               cmd_ch_q, cmd_ch_d;
   logic              cmd_src_q, cmd_src_d;
   logic [NUM_CH-1:0] arb_gnt, sched_gnt;
   ch_t               arb_idx;
   logic              arb_valid;
   logic              slot_free, hs, arb_en, req_take, sched_take;

   // Tag FIFO
   tag_t             tag_mem_q [TAG_DEPTH];
   tag_t             tag_head, tag_push;
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q, fifo_cnt, occ;
   logic             fifo_empty, push, pop;

   // Result path
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   ch_t                   out_ch_q;
   logic                  out_src_q;
   logic                  mismatch_q, mismatch_d, orphan_q, orphan_d;

   always_comb begin
      due   = '0;
      cnt_d = cnt_q;
      rate  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rate = ch_rate[i*RATE_WIDTH +: RATE_WIDTH];
         if (!ch_enable[i]) begin
            cnt_d[i] = rate;
         end else if (tick) begin
            if (cnt_q[i] == '0) begin
               due[i]   = 1'b1;
               cnt_d[i] = rate;
            end else begin
               cnt_d[i] = cnt_q[i] - 1'b1;
            end
         end
      end
   end

   adc_rr_arbiter u_arb (
      .req_i   (pending_q),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (fifo_cnt == '0);
   assign tag_head   = tag_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign hs         = cmd_valid_q && cmd_ready;
   assign push       = hs;
   assign pop        = res_valid && !fifo_empty;
   assign tag_push   = '{ch: cmd_ch_q, src: cmd_src_q};
   assign slot_free  = !cmd_valid_q || cmd_ready;

   // A command in the slot already owns a FIFO entry, so a new grant needs a free entry
   // beyond it; a pop in this cycle releases one.
   assign occ    = fifo_cnt + {{PTR_W{1'b0}}, cmd_valid_q} - {{PTR_W{1'b0}}, pop};
   assign arb_en = slot_free && (occ < (PTR_W+1)'(TAG_DEPTH));

`ifdef ADC_SCHED_ONDEMAND_EN
   assign req_take = req_valid && arb_en;
`else
   logic unused_req;
   assign unused_req = ^{req_valid, req_ch};
   assign req_take   = 1'b0;
`endif

   assign sched_take = arb_en && !req_take && arb_valid;
   assign sched_gnt  = sched_take ? arb_gnt : '0;

   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_ch_d    = cmd_ch_q;
      cmd_src_d   = cmd_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (hs) begin
         cmd_valid_d = 1'b0;
      end
      if (req_take) begin
         cmd_valid_d = 1'b1;
         cmd_ch_d    = req_ch;
         cmd_src_d   = SRC_DEMAND;
      end else if (sched_take) begin
         cmd_valid_d = 1'b1;
         cmd_ch_d    = arb_idx;
         cmd_src_d   = SRC_SCHED;
         rr_ptr_d    = arb_idx;
      end
   end

   // A channel granted and re-due in the same cycle stays pending without an overrun.
   always_comb begin
      pending_d  = ((pending_q & ~sched_gnt) | due) & ch_enable;
      ovr_set    = due & pending_q & ~sched_gnt;
      overrun_d  = (overrun_q & ~{NUM_CH{err_clr}}) | ovr_set;
      mismatch_d = (mismatch_q & ~err_clr) | (pop && (res_ch != tag_head.ch));
      orphan_d   = (orphan_q & ~err_clr) | (res_valid && fifo_empty);
   end

   always_ff @(posedge CLK or negedge rstn) begin
      if (!rstn) begin
         cnt_q       <= '0;
         pending_q   <= '0;
         overrun_q   <= '0;
         rr_ptr_q    <= ch_t'(NUM_CH - 1);
         cmd_valid_q <= 1'b0;
         cmd_ch_q    <= '0;
         cmd_src_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_src_q   <= 1'b0;
         mismatch_q  <= 1'b0;
         orphan_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         rr_ptr_q    <= rr_ptr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_ch_q    <= cmd_ch_d;
         cmd_src_q   <= cmd_src_d;
         mismatch_q  <= mismatch_d;
         orphan_q    <= orphan_d;
         out_valid_q <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + (PTR_W+1)'(1);
            out_data_q <= res_data;
            out_ch_q   <= tag_head.ch;
            out_src_q  <= tag_head.src;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         tag_mem_q[wr_ptr_q[PTR_W-1:0]] <= tag_push;
      end
   end

   assign req_ready    = req_take;
   assign cmd_valid    = cmd_valid_q;
   assign cmd_ch       = cmd_ch_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_ch       = out_ch_q;
   assign out_src      = out_src_q;
   assign overrun      = overrun_q;
   assign err_mismatch = mismatch_q;
   assign err_orphan   = orphan_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler; expectations follow the ADC_SCHED_ONDEMAND_EN setting.
module tb_adc_scan_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        tick;
   logic [7:0]  ch_enable;
   logic [63:0] ch_rate;
   logic        req_valid;
   logic [2:0]  req_ch;
   logic        req_ready;
   logic        cmd_valid;
   logic [2:0]  cmd_ch;
   logic        cmd_ready;
   logic        res_valid;
   logic [7:0]  res_data;
   logic [2:0]  res_ch;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_src;
   logic [7:0]  overrun;
   logic        err_mismatch;
   logic        err_orphan;
   logic        err_clr;

   int total = 0;
   int bad   = 0;
   int cc_q[$], ct_q[$], oc_q[$], os_q[$], od_q[$];

`ifdef ADC_SCHED_ONDEMAND_EN
   localparam bit OnDemand = 1'b1;
`else
   localparam bit OnDemand = 1'b0;
`endif

   always #5 clk = ~clk;

   adc_scan_scheduler dut (
      .CLK          (clk),
      .rstn         (rstn),
      .tick         (tick),
      .ch_enable    (ch_enable),
      .ch_rate      (ch_rate),
      .req_valid    (req_valid),
      .req_ch       (req_ch),
      .req_ready    (req_ready),
      .cmd_valid    (cmd_valid),
      .cmd_ch       (cmd_ch),
      .cmd_ready    (cmd_ready),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_ch       (res_ch),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ch       (out_ch),
      .out_src      (out_src),
      .overrun      (overrun),
      .err_mismatch (err_mismatch),
      .err_orphan   (err_orphan),
      .err_clr      (err_clr)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] en, input logic [63:0] rate, input logic rdy);
      rstn      = 1'b0;
      tick      = 1'b0;
      ch_enable = en;
      ch_rate   = rate;
      req_valid = 1'b0;
      req_ch    = '0;
      cmd_ready = rdy;
      res_valid = 1'b0;
      res_data  = '0;
      res_ch    = '0;
      err_clr   = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   // Runs n cycles, logging handshakes and outputs; with echo, the driver returns one result
   // the cycle after each handshake, channel xor'd with xr and data 0x50 + returned channel.
   task automatic run(input int n, input int period, input logic [2:0] xr, input bit echo);
      logic       hs, hs_prev;
      logic [2:0] ch_prev;
      hs_prev = 1'b0;
      ch_prev = '0;
      cc_q.delete(); ct_q.delete(); oc_q.delete(); os_q.delete(); od_q.delete();
      for (int i = 0; i < n; i++) begin
         if (out_valid) begin
            oc_q.push_back(int'(out_ch));
            os_q.push_back(int'(out_src));
            od_q.push_back(int'(out_data));
         end
         hs = cmd_valid && cmd_ready;
         if (hs) begin
            cc_q.push_back(int'(cmd_ch));
            ct_q.push_back(i);
         end
         tick      = (period != 0) && (i % period == 0);
         res_valid = echo && hs_prev;
         res_ch    = ch_prev ^ xr;
         res_data  = 8'h50 + {5'b0, ch_prev ^ xr};
         hs_prev   = hs;
         ch_prev   = cmd_ch;
         step();
      end
      tick      = 1'b0;
      res_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e1c[4], e1d[4], e2t[3], e6c[4];
      int e4c[3], e4s[3];
      int n4;

      // Reset state
      do_reset(8'h05, 64'h0, 1'b1);
      check_val("rst_cmd_valid", cmd_valid, 0);
      check_val("rst_cmd_ch", cmd_ch, 0);
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_overrun", overrun, 0);
      check_val("rst_errs", {err_mismatch, err_orphan}, 0);

      // Two channels at rate 0, one tick every 6 cycles: alternating 0,2
      e1c = '{0, 2, 0, 2};
      e1d = '{8'h50, 8'h52, 8'h50, 8'h52};
      run(12, 6, 3'd0, 1'b1);
      check_val("t1_ncmd", cc_q.size(), 4);
      check_val("t1_nout", oc_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check_val("t1_cmd_ch", (k < cc_q.size()) ? cc_q[k] : -1, e1c[k]);
         check_val("t1_out_ch", (k < oc_q.size()) ? oc_q[k] : -1, e1c[k]);
         check_val("t1_out_src", (k < os_q.size()) ? os_q[k] : -1, 0);
         check_val("t1_out_data", (k < od_q.size()) ? od_q[k] : -1, e1d[k]);
      end
      check_val("t1_first_cycle", (cc_q.size() > 0) ? ct_q[0] : -1, 2);

      // ch3 at rate 2, tick every 10 cycles: due on ticks 0, 3, 6
      do_reset(8'h08, 64'h0000_0000_0200_0000, 1'b1);
      e2t = '{2, 32, 62};
      run(64, 10, 3'd0, 1'b0);
      check_val("t2_ncmd", cc_q.size(), 3);
      for (int k = 0; k < 3; k++) begin
         check_val("t2_cmd_cycle", (k < ct_q.size()) ? ct_q[k] : -1, e2t[k]);
         check_val("t2_cmd_ch", (k < cc_q.size()) ? cc_q[k] : -1, 3);
      end

      // Stalled driver: first due is granted into the slot, second pends, third overruns
      do_reset(8'h02, 64'h0, 1'b0);
      run(8, 3, 3'd0, 1'b0);
      check_val("t3_nhs", cc_q.size(), 0);
      check_val("t3_cmd_valid", cmd_valid, 1);
      check_val("t3_cmd_ch", cmd_ch, 1);
      check_val("t3_overrun", overrun, 8'h02);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_val("t3_clr", overrun, 0);
      tick    = 1'b1;
      err_clr = 1'b1;
      step();
      tick    = 1'b0;
      err_clr = 1'b0;
      check_val("t3_set_wins", overrun, 8'h02);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_val("t3_clr2", overrun, 0);

      // On-demand request for ch5 while ch0 and ch1 become pending
      do_reset(8'h03, 64'h0, 1'b1);
      tick      = 1'b1;
      req_valid = 1'b1;
      req_ch    = 3'd5;
      #1;
      check_val("t4_req_ready", req_ready, OnDemand ? 1 : 0);
      step();
      tick      = 1'b0;
      req_valid = 1'b0;
      run(8, 0, 3'd0, 1'b1);
      if (OnDemand) begin
         e4c = '{5, 0, 1};
         e4s = '{1, 0, 0};
         n4  = 3;
      end else begin
         e4c = '{0, 1, 0};
         e4s = '{0, 0, 0};
         n4  = 2;
      end
      check_val("t4_ncmd", cc_q.size(), n4);
      check_val("t4_nout", oc_q.size(), n4);
      for (int k = 0; k < n4; k++) begin
         check_val("t4_cmd_ch", (k < cc_q.size()) ? cc_q[k] : -1, e4c[k]);
         check_val("t4_out_ch", (k < oc_q.size()) ? oc_q[k] : -1, e4c[k]);
         check_val("t4_out_src", (k < os_q.size()) ? os_q[k] : -1, e4s[k]);
      end

      // Driver returns ch4 for a ch6 command, then an orphan result
      do_reset(8'h40, 64'h0, 1'b1);
      run(6, 100, 3'b010, 1'b1);
      check_val("t5_nout", oc_q.size(), 1);
      check_val("t5_out_ch", (oc_q.size() > 0) ? oc_q[0] : -1, 6);
      check_val("t5_out_data", (od_q.size() > 0) ? od_q[0] : -1, 8'h54);
      check_val("t5_mismatch", err_mismatch, 1);
      check_val("t5_no_orphan", err_orphan, 0);
      res_valid = 1'b1;
      res_ch    = 3'd0;
      step();
      res_valid = 1'b0;
      check_val("t5_orphan_no_out", out_valid, 0);
      check_val("t5_orphan", err_orphan, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_val("t5_clr", {err_mismatch, err_orphan}, 0);

      // Reset with a tag in flight: the late result is an orphan
      do_reset(8'h01, 64'h0, 1'b1);
      run(4, 100, 3'd0, 1'b0);
      check_val("t5r_ncmd", cc_q.size(), 1);
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      check_val("t5r_orphan", err_orphan, 1);
      check_val("t5r_no_out", out_valid, 0);

      // Tag FIFO fill: four commands, then held off until one result frees a slot
      do_reset(8'h1f, 64'h0, 1'b1);
      e6c = '{0, 1, 2, 3};
      run(8, 100, 3'd0, 1'b0);
      check_val("t6_ncmd", cc_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check_val("t6_cmd_ch", (k < cc_q.size()) ? cc_q[k] : -1, e6c[k]);
      end
      check_val("t6_held_off", cmd_valid, 0);
      res_valid = 1'b1;
      res_ch    = 3'd0;
      res_data  = 8'h11;
      step();
      res_valid = 1'b0;
      check_val("t6_resume_valid", cmd_valid, 1);
      check_val("t6_resume_ch", cmd_ch, 4);
      check_val("t6_out_valid", out_valid, 1);
      check_val("t6_out_ch", out_ch, 0);
      check_val("t6_out_data", out_data, 8'h11);
      check_val("t6_no_mismatch", err_mismatch, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
